hazard_ctrl_unit: RTL and testbench
===================================

// Module: hazard_ctrl_unit
// PURPOSE
//  Pipeline hazard sequencer; sits alongside forwarding_unit in the 5-stage core.
//  Handles the cases forwarding cannot resolve:
//   - load-use (1-cycle bubble);
//   - multi-cycle MUL/DIV (holds the pipe until the MDU completes);
//   - taken branch/jump redirect (flushes the younger stages).
//  Drives the stall/flush enables of the PC, IF/ID and ID/EX registers, plus the EX/MEM bubble.
// PARAMETERS
//  MDU_TIMEOUT  64  max cycles in MDU_WAIT before forced exit; must be >=2
//  CNT_W        32  width of the saturating performance counters
// PORTS
//  clk                input   1   core clock
//  rst_n              input   1   synchronous active-low reset
//  ID_rs1_addr_i      input   5   rs1 of instruction in ID
//  ID_rs2_addr_i      input   5   rs2 of instruction in ID
//  ID_use_rs1_i       input   1   ID instruction reads rs1
//  ID_use_rs2_i       input   1   ID instruction reads rs2
//  EX_rd_addr_i       input   5   rd of instruction in EX
//  EX_MemRead_i       input   1   EX instruction is a load
//  EX_mdu_op_i        input   1   EX instruction is MUL/DIV/REM
//  EX_redirect_i      input   1   EX resolved a taken branch/jump
//  mdu_done_i         input   1   MDU result valid (1-cycle pulse)
//  PC_stall_o         output  1   hold PC
//  IF_ID_stall_o      output  1   hold IF/ID
//  ID_EX_stall_o      output  1   hold ID/EX
//  IF_ID_flush_o      output  1   clear IF/ID to NOP
//  ID_EX_flush_o      output  1   clear ID/EX to NOP (bubble)
//  EX_MEM_bubble_o    output  1   write NOP into EX/MEM
//  mdu_start_o        output  1   start pulse to MDU (samples EX operands)
//  mdu_timeout_o      output  1   sticky: an MDU op hit MDU_TIMEOUT
//  stall_cycles_o     output  CNT_W  saturating count of cycles with PC_stall_o=1
//  flush_events_o     output  CNT_W  saturating count of cycles with IF_ID_flush_o=1
// BEHAVIOUR
//  States: RUN, MDU_WAIT. Sync reset (rst_n=0 at posedge) clears everything:
//   - state=RUN; wait counter=0; mdu_timeout_o=0; both perf counters=0.
//   - Reset mid-MDU_WAIT aborts the wait; no start/done bookkeeping survives.
//  All stall/flush/start outputs are combinational from state + inputs; all are 0 during reset.
//  load_use = EX_MemRead_i && EX_rd_addr_i!=0 &&
//             ((ID_use_rs1_i && ID_rs1_addr_i==EX_rd_addr_i) || (ID_use_rs2_i && ID_rs2_addr_i==EX_rd_addr_i))
//  RUN, priority high->low:
//   1. EX_redirect_i: IF_ID_flush_o=ID_EX_flush_o=1, no stalls; load_use ignored (ID is squashed); stay RUN.
//   2. EX_mdu_op_i: mdu_start_o=1 (exactly one cycle);
//      PC/IF_ID/ID_EX stall=1, EX_MEM_bubble_o=1; next state MDU_WAIT, wait counter<=1.
//   3. load_use: PC_stall_o=IF_ID_stall_o=1, ID_EX_flush_o=1 for exactly one cycle; stay RUN.
//      Next cycle the load is in MEM and forwarding covers it.
//   4. else all outputs 0.
//   mdu_done_i in RUN is ignored.
//  MDU_WAIT:
//   - Each cycle: mdu_start_o=0; EX_redirect_i and load_use ignored; counter increments.
//   - mdu_done_i=0 and counter<MDU_TIMEOUT: PC/IF_ID/ID_EX stall=1, EX_MEM_bubble_o=1.
//   - mdu_done_i=1: all stalls and bubble 0 in the same cycle (result latched into EX/MEM); next RUN.
//   - counter==MDU_TIMEOUT without done: behave as done (outputs 0, next RUN), set mdu_timeout_o.
//     mdu_timeout_o stays set until reset.
//  Latency: MDU op with done N cycles after start -> N+1 stall cycles total (start cycle included).
//  Counters: +1 per qualifying cycle, saturate at all-ones, never wrap.
// TESTING
//  T1 reset, idle inputs: all outputs 0, counters 0; rst_n low mid-MDU_WAIT -> RUN next cycle, outputs 0.
//  T2 EX load rd=5, ID rs1=5 use_rs1=1: exactly 1 cycle PC/IF_ID stall + ID_EX flush; rd=0 -> no stall.
//  T3 EX_mdu_op=1, done 4 cycles after start: start pulse 1 cycle, 5 stall cycles, stall_cycles_o=5.
//  T4 EX_redirect=1 with load_use true: IF_ID/ID_EX flush=1, stalls 0, flush_events_o=1.
//  T5 MDU_TIMEOUT=4, done never: stall released at counter 4, mdu_timeout_o=1 and stays set.
//  T6 CNT_W=3, 10 load-use stalls: stall_cycles_o saturates at 7.

Source files
------------

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard sequencer: load-use bubbles, MUL/DIV hold-off and redirect flushes
// for the 5-stage core, plus saturating stall/flush performance counters.
module hazard_ctrl_unit #(
    parameter int unsigned MDU_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       ID_rs1_addr_i,
    input  logic [4:0]       ID_rs2_addr_i,
    input  logic             ID_use_rs1_i,
    input  logic             ID_use_rs2_i,
    input  logic [4:0]       EX_rd_addr_i,
    input  logic             EX_MemRead_i,
    input  logic             EX_mdu_op_i,
    input  logic             EX_redirect_i,
    input  logic             mdu_done_i,
    output logic             PC_stall_o,
    output logic             IF_ID_stall_o,
    output logic             ID_EX_stall_o,
    output logic             IF_ID_flush_o,
    output logic             ID_EX_flush_o,
    output logic             EX_MEM_bubble_o,
    output logic             mdu_start_o,
    output logic             mdu_timeout_o,
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic [CNT_W-1:0] flush_events_o
);

    localparam int unsigned           WCNT_W = $clog2(MDU_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0]     TMO    = WCNT_W'(MDU_TIMEOUT);

    typedef enum logic {RUN, MDU_WAIT} state_e;

    state_e            state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;
    logic              load_use;

    assign load_use = EX_MemRead_i && (EX_rd_addr_i != 5'd0) &&
                      ((ID_use_rs1_i && (ID_rs1_addr_i == EX_rd_addr_i)) ||
                       (ID_use_rs2_i && (ID_rs2_addr_i == EX_rd_addr_i)));

    always_comb begin
        PC_stall_o      = 1'b0;
        IF_ID_stall_o   = 1'b0;
        ID_EX_stall_o   = 1'b0;
        IF_ID_flush_o   = 1'b0;
        ID_EX_flush_o   = 1'b0;
        EX_MEM_bubble_o = 1'b0;
        mdu_start_o     = 1'b0;
        state_d         = state_q;
        wcnt_d          = wcnt_q;
        timeout_d       = timeout_q;
        // Everything is gated by rst_n so the control outputs read 0 throughout reset.
        if (rst_n) begin
            unique case (state_q)
                RUN: begin
                    if (EX_redirect_i) begin
                        IF_ID_flush_o = 1'b1;
                        ID_EX_flush_o = 1'b1;
                    end else if (EX_mdu_op_i) begin
                        mdu_start_o     = 1'b1;
                        PC_stall_o      = 1'b1;
                        IF_ID_stall_o   = 1'b1;
                        ID_EX_stall_o   = 1'b1;
                        EX_MEM_bubble_o = 1'b1;
                        state_d         = MDU_WAIT;
                        wcnt_d          = WCNT_W'(1);
                    end else if (load_use) begin
                        PC_stall_o    = 1'b1;
                        IF_ID_stall_o = 1'b1;
                        ID_EX_flush_o = 1'b1;
                    end
                end
                MDU_WAIT: begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                    if (mdu_done_i) begin
                        state_d = RUN;
                        wcnt_d  = '0;
                    end else if (wcnt_q == TMO) begin
                        state_d   = RUN;
                        wcnt_d    = '0;
                        timeout_d = 1'b1;
                    end else begin
                        PC_stall_o      = 1'b1;
                        IF_ID_stall_o   = 1'b1;
                        ID_EX_stall_o   = 1'b1;
                        EX_MEM_bubble_o = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= RUN;
            wcnt_q      <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            timeout_q <= timeout_d;
            if (PC_stall_o && !(&stall_cnt_q))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (IF_ID_flush_o && !(&flush_cnt_q))
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign mdu_timeout_o  = timeout_q;
    assign stall_cycles_o = stall_cnt_q;
    assign flush_events_o = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: a default instance plus a short-timeout,
// 3-bit-counter instance driven by the same stimulus.
module tb_hazard_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs1, rs2, rd;
    logic       use1, use2, memrd, mdu_op, redir, done;

    logic       a_pcs, a_ifs, a_ids, a_iff, a_idf, a_bub, a_st, a_to;
    logic [31:0] a_stall, a_flush;
    logic       b_pcs, b_ifs, b_ids, b_iff, b_idf, b_bub, b_st, b_to;
    logic [2:0] b_stall, b_flush;

    int unsigned n_chk = 0;
    int unsigned n_pass = 0;

    always #5 clk = ~clk;

    hazard_ctrl_unit dut_a (
        .clk(clk), .rst_n(rst_n),
        .ID_rs1_addr_i(rs1), .ID_rs2_addr_i(rs2), .ID_use_rs1_i(use1), .ID_use_rs2_i(use2),
        .EX_rd_addr_i(rd), .EX_MemRead_i(memrd), .EX_mdu_op_i(mdu_op), .EX_redirect_i(redir),
        .mdu_done_i(done),
        .PC_stall_o(a_pcs), .IF_ID_stall_o(a_ifs), .ID_EX_stall_o(a_ids),
        .IF_ID_flush_o(a_iff), .ID_EX_flush_o(a_idf), .EX_MEM_bubble_o(a_bub),
        .mdu_start_o(a_st), .mdu_timeout_o(a_to),
        .stall_cycles_o(a_stall), .flush_events_o(a_flush)
    );

    hazard_ctrl_unit #(.MDU_TIMEOUT(4), .CNT_W(3)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .ID_rs1_addr_i(rs1), .ID_rs2_addr_i(rs2), .ID_use_rs1_i(use1), .ID_use_rs2_i(use2),
        .EX_rd_addr_i(rd), .EX_MemRead_i(memrd), .EX_mdu_op_i(mdu_op), .EX_redirect_i(redir),
        .mdu_done_i(done),
        .PC_stall_o(b_pcs), .IF_ID_stall_o(b_ifs), .ID_EX_stall_o(b_ids),
        .IF_ID_flush_o(b_iff), .ID_EX_flush_o(b_idf), .EX_MEM_bubble_o(b_bub),
        .mdu_start_o(b_st), .mdu_timeout_o(b_to),
        .stall_cycles_o(b_stall), .flush_events_o(b_flush)
    );

    // Vector order: {PC_stall, IF_ID_stall, ID_EX_stall, IF_ID_flush, ID_EX_flush, bubble, start}
    logic [6:0] oa, ob;
    assign oa = {a_pcs, a_ifs, a_ids, a_iff, a_idf, a_bub, a_st};
    assign ob = {b_pcs, b_ifs, b_ids, b_iff, b_idf, b_bub, b_st};

    localparam logic [6:0] O_IDLE  = 7'b0000000;
    localparam logic [6:0] O_LU    = 7'b1100100;
    localparam logic [6:0] O_FLUSH = 7'b0001100;
    localparam logic [6:0] O_START = 7'b1110011;
    localparam logic [6:0] O_WAIT  = 7'b1110010;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0; use1 = 1'b0; use2 = 1'b0;
        memrd = 1'b0; mdu_op = 1'b0; redir = 1'b0; done = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        // T1: reset state, outputs forced low during reset
        idle();
        rst_n = 1'b0;
        mdu_op = 1'b1;
        @(negedge clk);
        chk("rst_outs_a", 32'(oa), 32'(O_IDLE));
        chk("rst_outs_b", 32'(ob), 32'(O_IDLE));
        tick();
        idle();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_outs", 32'(oa), 32'(O_IDLE));
        chk("rst_stall_cnt", a_stall, 32'd0);
        chk("rst_flush_cnt", a_flush, 32'd0);
        chk("rst_timeout", 32'(a_to), 32'd0);
        tick();

        // T2: load-use detection
        memrd = 1'b1; rd = 5'd5; rs1 = 5'd5; use1 = 1'b1;
        @(negedge clk);
        chk("lu_rs1", 32'(oa), 32'(O_LU));
        tick();
        chk("lu_cnt1", a_stall, 32'd1);
        idle();
        @(negedge clk);
        chk("lu_release", 32'(oa), 32'(O_IDLE));
        tick();
        memrd = 1'b1; rd = 5'd0; rs1 = 5'd0; use1 = 1'b1;
        @(negedge clk);
        chk("lu_rd0", 32'(oa), 32'(O_IDLE));
        tick();
        memrd = 1'b1; rd = 5'd7; rs1 = 5'd3; use1 = 1'b1; rs2 = 5'd7; use2 = 1'b1;
        @(negedge clk);
        chk("lu_rs2", 32'(oa), 32'(O_LU));
        tick();
        use2 = 1'b0;
        @(negedge clk);
        chk("lu_rs2_unused", 32'(oa), 32'(O_IDLE));
        tick();
        memrd = 1'b0; use2 = 1'b1;
        @(negedge clk);
        chk("lu_not_load", 32'(oa), 32'(O_IDLE));
        tick();
        chk("lu_cnt2", a_stall, 32'd2);

        // T4: redirect beats load-use and MDU start
        idle();
        memrd = 1'b1; rd = 5'd9; rs1 = 5'd9; use1 = 1'b1; redir = 1'b1;
        @(negedge clk);
        chk("redir_lu", 32'(oa), 32'(O_FLUSH));
        tick();
        chk("redir_flush_cnt", a_flush, 32'd1);
        chk("redir_stall_cnt", a_stall, 32'd2);
        idle();
        redir = 1'b1; mdu_op = 1'b1;
        @(negedge clk);
        chk("redir_mdu", 32'(oa), 32'(O_FLUSH));
        tick();
        idle();
        @(negedge clk);
        chk("redir_stay_run", 32'(oa), 32'(O_IDLE));
        tick();
        chk("redir_flush_cnt2", a_flush, 32'd2);

        // T3: MDU op, done 4 cycles after start -> 5 stall cycles
        do_reset();
        mdu_op = 1'b1;
        @(negedge clk);
        chk("mdu_start", 32'(oa), 32'(O_START));
        tick();
        mdu_op = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            redir = (i == 2);
            memrd = 1'b1; rd = 5'd4; rs1 = 5'd4; use1 = 1'b1;
            @(negedge clk);
            chk($sformatf("mdu_wait%0d", i), 32'(oa), 32'(O_WAIT));
            tick();
        end
        idle();
        done = 1'b1;
        @(negedge clk);
        chk("mdu_done", 32'(oa), 32'(O_IDLE));
        tick();
        done = 1'b0;
        @(negedge clk);
        chk("mdu_back_run", 32'(oa), 32'(O_IDLE));
        chk("mdu_stall_cnt", a_stall, 32'd5);
        chk("mdu_no_timeout", 32'(a_to), 32'd0);
        tick();

        // T5: timeout on the MDU_TIMEOUT=4 instance
        do_reset();
        mdu_op = 1'b1;
        @(negedge clk);
        chk("to_start", 32'(ob), 32'(O_START));
        tick();
        mdu_op = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            chk($sformatf("to_wait%0d", i), 32'(ob), 32'(O_WAIT));
            tick();
        end
        @(negedge clk);
        chk("to_release", 32'(ob), 32'(O_IDLE));
        chk("to_a_still_wait", 32'(oa), 32'(O_WAIT));
        tick();
        chk("to_flag", 32'(b_to), 32'd1);
        chk("to_stall_cnt", 32'(b_stall), 32'd4);
        tick();
        tick();
        chk("to_sticky", 32'(b_to), 32'd1);
        chk("to_b_idle", 32'(ob), 32'(O_IDLE));
        done = 1'b1;
        @(negedge clk);
        chk("to_a_done", 32'(oa), 32'(O_IDLE));
        tick();
        done = 1'b0;
        chk("to_a_no_flag", 32'(a_to), 32'd0);

        // T1b: reset in the middle of MDU_WAIT
        mdu_op = 1'b1;
        tick();
        mdu_op = 1'b0;
        @(negedge clk);
        chk("rstw_waiting", 32'(oa), 32'(O_WAIT));
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstw_in_reset", 32'(oa), 32'(O_IDLE));
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstw_run_a", 32'(oa), 32'(O_IDLE));
        chk("rstw_run_b", 32'(ob), 32'(O_IDLE));
        chk("rstw_to_clr", 32'(b_to), 32'd0);
        chk("rstw_cnt_clr", a_stall, 32'd0);
        tick();

        // T6: 10 load-use stalls saturate the 3-bit counter
        memrd = 1'b1; rd = 5'd12; rs2 = 5'd12; use2 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("sat_lu%0d", i), 32'(ob), 32'(O_LU));
            tick();
        end
        idle();
        chk("sat_b", 32'(b_stall), 32'd7);
        chk("sat_a", a_stall, 32'd10);
        tick();
        chk("sat_hold", 32'(b_stall), 32'd7);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
